multi_ball_draw_checker: RTL
============================

# multi_ball_draw_checker

Pipelined, multi-ball successor to the single-ball draw checker in the pong video path. For every pixel the VGA timing generator presents, decides whether any of NUM_BALLS square balls covers it, reports the winning ball index, and (optionally) accumulates per-frame ball-overlap events for the game logic. Ball positions are double-buffered and swap only at frame start, so game logic may update them mid-frame without tearing.

## Interface
- NUM_BALLS, 2: number of balls, 1..8
- H_CNT_WID, 10: width of the horizontal pixel counter
- V_CNT_WID, 10: width of the vertical pixel counter
- BALL_PIXSIZE, 8: ball edge length in pixels, ≥1
- PIPELINE_STAGES, 2: pixel-in to result-out latency in cycles, ≥1
- CLK  in  1  pixel clock, single clock domain
- nRESET  in  1  asynchronous, active-low reset
- frameStart  in  1  one-cycle pulse at the first pixel of a frame
- pixelValid  in  1  drawX/drawY valid (visible area)
- drawX  in  H_CNT_WID  current pixel column
- drawY  in  V_CNT_WID  current pixel row
- ballX  in  NUM_BALLS×H_CNT_WID  pending left edge per ball
- ballY  in  NUM_BALLS×V_CNT_WID  pending top edge per ball
- ballEnable  in  NUM_BALLS  pending per-ball visibility
- outValid  out  1  delayed pixelValid
- isBallPos  out  1  some enabled ball covers the pixel
- ballIdx  out  max(1,clog2(NUM_BALLS))  lowest-index covering ball, 0 if none
- overlapMask  out  NUM_BALLS  balls that overlapped another ball during the previous frame

## Operation
- Shadow registers: ballX/ballY/ballEnable are captured into active registers on a cycle with frameStart=1; all comparisons use active registers only.
- The comparison for the pixel presented on the frameStart cycle already uses the newly captured values (capture and compare of that pixel are consistent: the compare stage reads the pending inputs on that cycle).
- Per-ball hit: enable && drawX ≥ X && drawX < X+BALL_PIXSIZE && drawY ≥ Y && drawY < Y+BALL_PIXSIZE. Sums are computed one bit wider than the counter, so a ball at the right/bottom edge does not wrap to column/row 0.
- Hit is forced to 0 when pixelValid=0.
- Priority: ballIdx = lowest index with hit. isBallPos = OR of hits.
- Overlap (see Configuration): a pixel with ≥2 hits ORs those balls' bits into an accumulator. On frameStart, overlapMask ← accumulator and accumulator ← hits-overlap of the frameStart pixel (new frame), never lost, never double-counted.

## Timing
- Latency exactly PIPELINE_STAGES cycles from drawX/drawY/pixelValid to outValid/isBallPos/ballIdx; stage 1 registers per-ball hits, remaining stages are delay registers; priority encode is done before the last register.
- Throughput one pixel per cycle, no stalls.
- overlapMask updates the cycle after frameStart and is stable for the whole frame.
- Reset: active registers, pipeline, accumulator, outValid, isBallPos, ballIdx, overlapMask all 0. Reset deassertion mid-frame: no output asserts until pipeline refills with valid pixels; balls stay disabled until the next frameStart.

## Configuration
- BALL_OVERLAP_DETECT_EN defined: overlap accumulator and overlapMask logic present as described.
- Not defined: accumulator omitted, overlapMask tied to 0; all other behaviour and latency unchanged.

## Structure
- pong_pkg: ball size, counter widths, ball-index width function, default NUM_BALLS.
- Sub-module ball_hit_compare: one ball's X/Y window comparison with widened arithmetic, instantiated NUM_BALLS times via generate.

## Test plan
- Single ball at (100,50), size 8, frameStart then sweep row 50: isBallPos high exactly for drawX 100..107, PIPELINE_STAGES cycles after each pixel; ballIdx=0.
- Ball at X=1020 with H_CNT_WID=10: drawX 1020..1023 hit, drawX 0..3 no hit (no wrap).
- Balls 0 and 1 both at (200,200): pixel (203,203) → isBallPos=1, ballIdx=0; after next frameStart overlapMask=2'b11 (0 when macro undefined).
- Change ballX mid-frame from 100 to 300 without frameStart: hits remain at 100..107; after frameStart hits at 300..307.
- pixelValid=0 at (100,50) with ball there: outValid=0, isBallPos=0.
- Assert nRESET=0 mid-frame with hits in flight: all outputs 0 immediately; after release no hits until next frameStart.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and helpers for the pong video path.
// Defaults for the ball geometry, counter widths and ball count.
package pong_pkg;

    localparam int DEF_NUM_BALLS       = 2;
    localparam int DEF_H_CNT_WID       = 10;
    localparam int DEF_V_CNT_WID       = 10;
    localparam int DEF_BALL_PIXSIZE    = 8;
    localparam int DEF_PIPELINE_STAGES = 2;

    // A single ball still needs a one-bit index port.
    function automatic int ball_idx_wid(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ball_hit_compare.sv
// One ball's square-window test against the current pixel.
// The right and bottom edges are computed one bit wider, so a ball at the screen edge does not wrap.
module ball_hit_compare
    import pong_pkg::*;
#(
    parameter int H_CNT_WID    = DEF_H_CNT_WID,
    parameter int V_CNT_WID    = DEF_V_CNT_WID,
    parameter int BALL_PIXSIZE = DEF_BALL_PIXSIZE
) (
    input  logic [H_CNT_WID-1:0] draw_x,
    input  logic [V_CNT_WID-1:0] draw_y,
    input  logic [H_CNT_WID-1:0] ball_x,
    input  logic [V_CNT_WID-1:0] ball_y,
    input  logic                 ball_en,
    input  logic                 pix_valid,
    output logic                 hit
);

    localparam logic [H_CNT_WID:0] SIZE_H = (H_CNT_WID+1)'(BALL_PIXSIZE);
    localparam logic [V_CNT_WID:0] SIZE_V = (V_CNT_WID+1)'(BALL_PIXSIZE);

    logic [H_CNT_WID:0] px_w;
    logic [H_CNT_WID:0] left_w;
    logic [H_CNT_WID:0] right_w;
    logic [V_CNT_WID:0] py_w;
    logic [V_CNT_WID:0] top_w;
    logic [V_CNT_WID:0] bottom_w;

    assign px_w     = {1'b0, draw_x};
    assign left_w   = {1'b0, ball_x};
    assign right_w  = left_w + SIZE_H;
    assign py_w     = {1'b0, draw_y};
    assign top_w    = {1'b0, ball_y};
    assign bottom_w = top_w + SIZE_V;

    assign hit = pix_valid && ball_en &&
                 (px_w >= left_w) && (px_w < right_w) &&
                 (py_w >= top_w)  && (py_w < bottom_w);

endmodule

// File: rtl/multi_ball_draw_checker.sv
// Pipelined multi-ball pixel coverage check with frame-synchronous ball position capture.
// Define BALL_OVERLAP_DETECT_EN to build the per-frame ball overlap accumulator.
module multi_ball_draw_checker
    import pong_pkg::*;
#(
    parameter int NUM_BALLS       = DEF_NUM_BALLS,
    parameter int H_CNT_WID       = DEF_H_CNT_WID,
    parameter int V_CNT_WID       = DEF_V_CNT_WID,
    parameter int BALL_PIXSIZE    = DEF_BALL_PIXSIZE,
    parameter int PIPELINE_STAGES = DEF_PIPELINE_STAGES,
    localparam int IDX_W          = ball_idx_wid(NUM_BALLS)
) (
    input  logic                           CLK,
    input  logic                           nRESET,
    input  logic                           frameStart,
    input  logic                           pixelValid,
    input  logic [H_CNT_WID-1:0]           drawX,
    input  logic [V_CNT_WID-1:0]           drawY,
    input  logic [NUM_BALLS*H_CNT_WID-1:0] ballX,
    input  logic [NUM_BALLS*V_CNT_WID-1:0] ballY,
    input  logic [NUM_BALLS-1:0]           ballEnable,
    output logic                           outValid,
    output logic                           isBallPos,
    output logic [IDX_W-1:0]               ballIdx,
    output logic [NUM_BALLS-1:0]           overlapMask
);

    logic [NUM_BALLS*H_CNT_WID-1:0] act_x_reg;
    logic [NUM_BALLS*V_CNT_WID-1:0] act_y_reg;
    logic [NUM_BALLS-1:0]           act_en_reg;

    logic [NUM_BALLS*H_CNT_WID-1:0] cmp_x;
    logic [NUM_BALLS*V_CNT_WID-1:0] cmp_y;
    logic [NUM_BALLS-1:0]           cmp_en;
    logic [NUM_BALLS-1:0]           hit_comb;

    logic [NUM_BALLS-1:0]           tap_hit;
    logic                           tap_valid;
    logic                           enc_any;
    logic [IDX_W-1:0]               enc_idx;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            act_x_reg  <= '0;
            act_y_reg  <= '0;
            act_en_reg <= '0;
        end else if (frameStart) begin
            act_x_reg  <= ballX;
            act_y_reg  <= ballY;
            act_en_reg <= ballEnable;
        end
    end

    // The frameStart pixel must already see the positions being captured on that cycle.
    assign cmp_x  = frameStart ? ballX      : act_x_reg;
    assign cmp_y  = frameStart ? ballY      : act_y_reg;
    assign cmp_en = frameStart ? ballEnable : act_en_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
            ball_hit_compare #(
                .H_CNT_WID    (H_CNT_WID),
                .V_CNT_WID    (V_CNT_WID),
                .BALL_PIXSIZE (BALL_PIXSIZE)
            ) u_cmp (
                .draw_x    (drawX),
                .draw_y    (drawY),
                .ball_x    (cmp_x[gi*H_CNT_WID +: H_CNT_WID]),
                .ball_y    (cmp_y[gi*V_CNT_WID +: V_CNT_WID]),
                .ball_en   (cmp_en[gi]),
                .pix_valid (pixelValid),
                .hit       (hit_comb[gi])
            );
        end

        // All but the last stage carry raw hit vectors; the encoder feeds the final register.
        if (PIPELINE_STAGES == 1) begin : g_no_dly
            assign tap_hit   = hit_comb;
            assign tap_valid = pixelValid;
        end else begin : g_dly
            localparam int DLY = PIPELINE_STAGES - 1;
            logic [NUM_BALLS-1:0] hit_dly_reg [DLY];
            logic [DLY-1:0]       valid_dly_reg;

            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET) begin
                    for (int i = 0; i < DLY; i++) begin
                        hit_dly_reg[i] <= '0;
                    end
                    valid_dly_reg <= '0;
                end else begin
                    hit_dly_reg[0]   <= hit_comb;
                    valid_dly_reg[0] <= pixelValid;
                    for (int i = 1; i < DLY; i++) begin
                        hit_dly_reg[i]   <= hit_dly_reg[i-1];
                        valid_dly_reg[i] <= valid_dly_reg[i-1];
                    end
                end
            end

            assign tap_hit   = hit_dly_reg[DLY-1];
            assign tap_valid = valid_dly_reg[DLY-1];
        end
    endgenerate

    always_comb begin
        enc_any = |tap_hit;
        enc_idx = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (tap_hit[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            outValid  <= 1'b0;
            isBallPos <= 1'b0;
            ballIdx   <= '0;
        end else begin
            outValid  <= tap_valid;
            isBallPos <= enc_any;
            ballIdx   <= enc_idx;
        end
    end

`ifdef BALL_OVERLAP_DETECT_EN
    logic [NUM_BALLS-1:0] acc_reg;
    logic                 multi_hit;

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multi_hit = (hit_comb & (hit_comb - NUM_BALLS'(1))) != '0;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            acc_reg     <= '0;
            overlapMask <= '0;
        end else if (frameStart) begin
            overlapMask <= acc_reg;
            acc_reg     <= multi_hit ? hit_comb : '0;
        end else if (multi_hit) begin
            acc_reg     <= acc_reg | hit_comb;
        end
    end
`else
    assign overlapMask = '0;
`endif

endmodule
